// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM encoding for the two-port RAM arbiter
package mem_arb_pkg;
    localparam int AW = 9;
    localparam int DW = 16;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports, RAM port and status of the arbiter
interface mem_arbiter_if;
    import mem_arb_pkg::*;
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    logic          ram_e;
    logic          ram_w;
    logic          ram_r;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_out;
    logic          busy;
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
        output ack0, rdata0, ack1, rdata1, ram_e, ram_w, ram_r, ram_addr, ram_d, busy
    );
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
        input  ack0, rdata0, ack1, rdata1, ram_e, ram_w, ram_r, ram_addr, ram_d, busy
    );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin pick; last remembers the port granted most recently
module mem_arb_rr (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic gnt,
    output logic valid
);
    logic last;
    assign valid = req0 | req1;
    assign gnt = (req0 & req1) ? ~last : req1;
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b1;
        else if (en && valid) last <= gnt;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 512x16 RAM between two requesters
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    state_t        state, nstate;
    logic          gnt, valid, gnt_q;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    mem_arb_rr u_rr (
        .clk   (clk),
        .rst   (rst),
        .req0  (bus.req0),
        .req1  (bus.req1),
        .en    (state == IDLE),
        .gnt   (gnt),
        .valid (valid)
    );
    always_comb begin
        nstate    = state == IDLE ? (valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
        sel_we    = gnt ? bus.we1 : bus.we0;
        sel_addr  = gnt ? bus.addr1 : bus.addr0;
        sel_wdata = gnt ? bus.wdata1 : bus.wdata0;
    end
    // RAM strobes are computed from the next state so they are registered yet aligned with ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt_q        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.ram_e    <= 1'b0;
            bus.ram_w    <= 1'b0;
            bus.ram_r    <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_d    <= '0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
        end else begin
            state     <= nstate;
            bus.busy  <= nstate != IDLE;
            bus.ram_e <= nstate == ACCESS;
            bus.ram_w <= nstate == ACCESS && sel_we;
            bus.ram_r <= nstate == ACCESS && !sel_we;
            bus.ack0  <= state == ACCESS && !gnt_q;
            bus.ack1  <= state == ACCESS && gnt_q;
            if (nstate == ACCESS) begin
                gnt_q        <= gnt;
                bus.ram_addr <= sel_addr;
                bus.ram_d    <= sel_wdata;
            end
            if (bus.ram_r && !gnt_q) bus.rdata0 <= bus.ram_out;
            if (bus.ram_r && gnt_q) bus.rdata1 <= bus.ram_out;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic checked against a transaction-level model
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (bus.ram_w) ram[bus.ram_addr] <= bus.ram_d;
    assign bus.ram_out = bus.ram_r ? ram[bus.ram_addr] : 'x;
    logic [DW-1:0] mdl_mem [int];
    logic [DW-1:0] mdl_rdata [2];
    int            mdl_last;
    logic          op_we [2];
    logic [AW-1:0] op_addr [2];
    logic [DW-1:0] op_wd [2];
    bit            pend [2];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] pool [9] = '{9'd0, 9'd3, 9'd5, 9'd6, 9'd7, 9'd8, 9'd100, 9'd448, 9'd511};
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic present(int p, logic r, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask
    task automatic set_op(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        op_we[p] = we; op_addr[p] = a; op_wd[p] = d; pend[p] = 1'b1;
    endtask
    // Each pending request is served as grant -> ack -> idle; the winner's inputs are scrambled after grant
    task automatic serve(bit drop_early);
        for (int p = 0; p < 2; p++) if (pend[p]) present(p, 1'b1, op_we[p], op_addr[p], op_wd[p]);
        while (pend[0] || pend[1]) begin
            int w;
            w = (pend[0] && pend[1]) ? 1 - mdl_last : (pend[1] ? 1 : 0);
            tick;
            chk("busy_access", bus.busy, 1);
            chk("ram_e_access", bus.ram_e, 1);
            chk("ram_w_access", bus.ram_w, op_we[w]);
            chk("ram_r_access", bus.ram_r, !op_we[w]);
            chk("ram_addr_access", bus.ram_addr, op_addr[w]);
            chk("ram_d_access", bus.ram_d, op_wd[w]);
            chk("ack_access", {bus.ack1, bus.ack0}, 2'b00);
            present(w, !drop_early, !op_we[w], op_addr[w] + 9'd1, ~op_wd[w]);
            mdl_last = w;
            if (op_we[w]) mdl_mem[op_addr[w]] = op_wd[w];
            else mdl_rdata[w] = mdl_mem[op_addr[w]];
            tick;
            chk("ack_resp", {bus.ack1, bus.ack0}, w ? 2'b10 : 2'b01);
            chk("rdata0_resp", bus.rdata0, mdl_rdata[0]);
            chk("rdata1_resp", bus.rdata1, mdl_rdata[1]);
            chk("busy_resp", bus.busy, 1);
            chk("strobes_resp", {bus.ram_e, bus.ram_w, bus.ram_r}, 3'b000);
            chk("ram_addr_hold", bus.ram_addr, op_addr[w]);
            present(w, 1'b0, op_we[w], op_addr[w], op_wd[w]);
            pend[w] = 1'b0;
            tick;
            chk("busy_idle", bus.busy, 0);
            chk("ack_idle", {bus.ack1, bus.ack0}, 2'b00);
            chk("strobes_idle", {bus.ram_e, bus.ram_w, bus.ram_r}, 3'b000);
        end
    endtask
    initial begin
        present(0, 1'b0, 1'b0, '0, '0);
        present(1, 1'b0, 1'b0, '0, '0);
        bus.req0 = 1'b1;
        repeat (3) tick;
        chk("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
        chk("rst_strobes", {bus.ram_e, bus.ram_w, bus.ram_r}, 3'b000);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_d", bus.ram_d, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_busy", bus.busy, 0);
        bus.req0 = 1'b0;
        rst = 1'b0;
        mdl_last = 1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        tick;
        chk("idle_busy", bus.busy, 0);
        chk("idle_ram_e", bus.ram_e, 0);
        set_op(0, 1'b1, 9'd0, 16'h0F0F);
        set_op(1, 1'b1, 9'd511, 16'hC3C3);
        serve(1'b0);
        set_op(0, 1'b1, 9'd8, 16'h8888);
        set_op(1, 1'b1, 9'd7, 16'h7777);
        serve(1'b0);
        set_op(0, 1'b1, 9'd3, 16'h00A5);
        serve(1'b0);
        set_op(0, 1'b0, 9'd3, 16'h0000);
        serve(1'b0);
        chk("rd3_rdata0", bus.rdata0, 16'h00A5);
        set_op(1, 1'b1, 9'd448, 16'h1234);
        serve(1'b0);
        set_op(0, 1'b0, 9'd448, 16'h0000);
        serve(1'b0);
        chk("rd448_rdata0", bus.rdata0, 16'h1234);
        set_op(0, 1'b0, 9'd0, 16'h0000);
        serve(1'b0);
        chk("rd0_rdata0", bus.rdata0, 16'h0F0F);
        set_op(0, 1'b1, 9'd5, 16'h5555);
        serve(1'b0);
        set_op(1, 1'b1, 9'd6, 16'h6666);
        serve(1'b0);
        set_op(0, 1'b0, 9'd5, 16'h0000);
        serve(1'b0);
        chk("rd5_rdata0", bus.rdata0, 16'h5555);
        set_op(0, 1'b1, 9'd7, 16'hA7A7);
        serve(1'b0);
        chk("wr7_rdata0_kept", bus.rdata0, 16'h5555);
        set_op(0, 1'b0, 9'd8, 16'h0000);
        serve(1'b0);
        chk("rd8_rdata0", bus.rdata0, 16'h8888);
        set_op(0, 1'b0, 9'd3, 16'h0000);
        serve(1'b1);
        present(1, 1'b1, 1'b0, 9'd448, 16'h0000);
        tick;
        chk("abort_ram_r", bus.ram_r, 1);
        rst = 1'b1;
        present(1, 1'b0, 1'b0, 9'd448, 16'h0000);
        tick;
        rst = 1'b0;
        chk("abort_ack1", bus.ack1, 0);
        chk("abort_rdata1", bus.rdata1, 0);
        chk("abort_busy", bus.busy, 0);
        mdl_last = 1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        tick;
        chk("abort_no_late_ack", {bus.ack1, bus.ack0}, 2'b00);
        present(0, 1'b1, 1'b1, 9'd100, 16'hBEEF);
        tick;
        rst = 1'b1;
        present(0, 1'b0, 1'b1, 9'd100, 16'hBEEF);
        tick;
        rst = 1'b0;
        chk("abort_wr_ack0", bus.ack0, 0);
        mdl_mem[100] = 16'hBEEF;
        set_op(0, 1'b0, 9'd100, 16'h0000);
        set_op(1, 1'b0, 9'd448, 16'h0000);
        serve(1'b0);
        chk("abort_wr_commit", bus.rdata0, 16'hBEEF);
        for (int i = 0; i < 60; i++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++)
                if (mask[p]) set_op(p, 1'($urandom), pool[$urandom_range(0, 8)], 16'($urandom));
            serve($urandom_range(0, 3) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
